// File: rtl/qpsk_bit_splitter_pkg.sv
// Shared QPSK transmit/receive definitions: default bit divider, pair-phase
// encoding and the I-first dibit mapping convention.
package qpsk_bit_splitter_pkg;

  localparam int QPSK_BIT_DIV_DEFAULT = 8;
  localparam bit QPSK_I_FIRST_DEFAULT = 1'b1;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  // Returns {I, Q} for a collected pair under the given I-first convention.
  function automatic logic [1:0] map_dibit(input logic first_bit,
                                           input logic second_bit,
                                           input logic i_first);
    return i_first ? {first_bit, second_bit} : {second_bit, first_bit};
  endfunction

endpackage

// File: rtl/bit_rate_divider.sv
// Bit-rate divider: free-running modulo-DIV counter while enabled, with a
// terminal-count tick gated by en.
module bit_rate_divider #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/qpsk_bit_splitter.sv
// Serial-to-dibit splitter for the QPSK transmit path: pairs consecutive
// sampled bits into held I/Q bits with a one-cycle sym_load per symbol.
module qpsk_bit_splitter
  import qpsk_bit_splitter_pkg::*;
#(
  parameter int BIT_DIV = QPSK_BIT_DIV_DEFAULT,
  parameter bit I_FIRST = QPSK_I_FIRST_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic bit_tick,
  output logic sel,
  output logic data_i,
  output logic data_q,
  output logic sym_load
);

  logic       w_tick;
  logic [1:0] w_dibit;
  phase_e     r_phase;
  logic       r_first_bit;
  logic       r_data_i;
  logic       r_data_q;
  logic       r_sym_load;

  bit_rate_divider #(.DIV(BIT_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  assign w_dibit = map_dibit(r_first_bit, din, I_FIRST);

  // en low clears everything, so a half-collected pair is never emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= PH_FIRST;
      r_first_bit <= 1'b0;
      r_data_i    <= 1'b0;
      r_data_q    <= 1'b0;
      r_sym_load  <= 1'b0;
    end else if (!en) begin
      r_phase     <= PH_FIRST;
      r_first_bit <= 1'b0;
      r_data_i    <= 1'b0;
      r_data_q    <= 1'b0;
      r_sym_load  <= 1'b0;
    end else begin
      r_sym_load <= 1'b0;
      if (w_tick) begin
        case (r_phase)
          PH_FIRST: begin
            r_first_bit <= din;
            r_phase     <= PH_SECOND;
          end
          PH_SECOND: begin
            r_data_i   <= w_dibit[1];
            r_data_q   <= w_dibit[0];
            r_sym_load <= 1'b1;
            r_phase    <= PH_FIRST;
          end
          default: r_phase <= PH_FIRST;
        endcase
      end
    end
  end

  assign bit_tick = w_tick;
  assign sel      = (r_phase == PH_SECOND);
  assign data_i   = r_data_i;
  assign data_q   = r_data_q;
  assign sym_load = r_sym_load;

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// Directed bench for qpsk_bit_splitter: three instances cover DIV=4 I-first,
// DIV=4 Q-first and the minimum DIV=2 divider.
module tb_qpsk_bit_splitter;

  logic clk;
  logic rst_n;
  logic en    [3];
  logic din   [3];
  logic tick  [3];
  logic sel   [3];
  logic di    [3];
  logic dq    [3];
  logic sl    [3];

  int n_pass;
  int n_tot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qpsk_bit_splitter #(.BIT_DIV(4), .I_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .din(din[0]), .bit_tick(tick[0]),
    .sel(sel[0]), .data_i(di[0]), .data_q(dq[0]), .sym_load(sl[0]));

  qpsk_bit_splitter #(.BIT_DIV(4), .I_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .din(din[1]), .bit_tick(tick[1]),
    .sel(sel[1]), .data_i(di[1]), .data_q(dq[1]), .sym_load(sl[1]));

  qpsk_bit_splitter #(.BIT_DIV(2), .I_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .din(din[2]), .bit_tick(tick[2]),
    .sel(sel[2]), .data_i(di[2]), .data_q(dq[2]), .sym_load(sl[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk($sformatf("%s u%0d sel", tag, u), sel[u], 1'b0);
    chk($sformatf("%s u%0d data_i", tag, u), di[u], 1'b0);
    chk($sformatf("%s u%0d data_q", tag, u), dq[u], 1'b0);
    chk($sformatf("%s u%0d sym_load", tag, u), sl[u], 1'b0);
  endtask

  // Enables unit u from an idle state and plays nbits (LSB first) on ticks.
  // Called just after an edge; the current cycle is cycle 1 after enable.
  task automatic run_stream(input int u, input int div, input bit ifirst,
                            input logic [63:0] bits, input int nbits,
                            input bit hand, input logic [1:0] h1, input logic [1:0] h2);
    logic e_sel, e_i, e_q, e_sl, fb, nx_sl, b, t_e;
    int idx;
    e_sel = 1'b0; e_i = 1'b0; e_q = 1'b0; e_sl = 1'b0; fb = 1'b0; idx = 0;
    en[u] = 1'b1;
    for (int k = 1; k <= nbits * div + 1; k++) begin
      t_e = (k % div == 0);
      chk($sformatf("u%0d k%0d tick", u, k), tick[u], t_e);
      chk($sformatf("u%0d k%0d sel", u, k), sel[u], e_sel);
      chk($sformatf("u%0d k%0d sym_load", u, k), sl[u], e_sl);
      chk($sformatf("u%0d k%0d dibit", u, k), {di[u], dq[u]}, {e_i, e_q});
      if (hand && k == 2 * div + 1)
        chk($sformatf("u%0d hand dibit1", u), {di[u], dq[u]}, h1);
      if (hand && nbits >= 4 && k == 4 * div + 1)
        chk($sformatf("u%0d hand dibit2", u), {di[u], dq[u]}, h2);
      nx_sl = 1'b0;
      if (t_e && idx < nbits) begin
        b = bits[idx];
        din[u] = b;
        if (!e_sel) fb = b;
        else begin
          {e_i, e_q} = ifirst ? {fb, b} : {b, fb};
          nx_sl = 1'b1;
        end
        e_sel = ~e_sel;
        idx++;
      end else begin
        din[u] = 1'($urandom_range(1));
      end
      e_sl = nx_sl;
      step();
    end
    en[u] = 1'b0;
    din[u] = 1'b0;
    step();
    chk_idle(u, "post-disable");
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst_n  = 1'b0;
    for (int u = 0; u < 3; u++) begin
      en[u]  = 1'b1;
      din[u] = 1'b0;
    end

    // Reset held with en high and din toggling: all outputs stay 0.
    for (int c = 0; c < 5; c++) begin
      step();
      for (int u = 0; u < 3; u++) begin
        din[u] = ~din[u];
        chk_idle(u, $sformatf("reset c%0d", c));
        chk($sformatf("reset c%0d u%0d tick", c, u), tick[u], 1'b0);
      end
    end
    for (int u = 0; u < 3; u++) en[u] = 1'b0;
    rst_n = 1'b1;
    step();

    // Basic pairing, stream 1,0,1,1: (I,Q) = (1,0) at cycle 9, (1,1) at 17.
    run_stream(0, 4, 1'b1, 64'b1101, 4, 1'b1, 2'b10, 2'b11);

    // Swapped mapping, same stream: (0,1) then (1,1).
    run_stream(1, 4, 1'b0, 64'b1101, 4, 1'b1, 2'b01, 2'b11);

    // Enable drop one cycle after the first tick of a pair (din=1).
    en[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      din[0] = (k == 4) ? 1'b1 : 1'b0;
      chk($sformatf("drop k%0d tick", k), tick[0], (k == 4));
      chk($sformatf("drop k%0d sym_load", k), sl[0], 1'b0);
      if (k < 5) step();
    end
    chk("drop sel before", sel[0], 1'b1);
    en[0] = 1'b0;
    step();
    chk_idle(0, "drop");
    chk("drop tick", tick[0], 1'b0);
    step();
    chk_idle(0, "drop hold");
    // Re-enable with 0,1: only (0,1) may appear, never the stale 1.
    run_stream(0, 4, 1'b1, 64'b10, 2, 1'b1, 2'b01, 2'b00);

    // Reset mid-symbol: one full pair (1,1), then the first bit of the next.
    en[0] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      din[0] = 1'b1;
      step();
    end
    chk("pre-reset sel", sel[0], 1'b1);
    chk("pre-reset dibit", {di[0], dq[0]}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle(0, "async reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Pairing restarts from FIRST: stream 1,0 -> (1,0).
    run_stream(0, 4, 1'b1, 64'b01, 2, 1'b1, 2'b10, 2'b00);

    // Minimum divider with a random 64-bit stream.
    run_stream(2, 2, 1'b1, {$urandom, $urandom}, 64, 1'b0, 2'b00, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/qpsk_bit_splitter.md
# qpsk_bit_splitter

Transmit-side serial-to-dibit splitter for the QPSK path. It samples a serial NRZ bitstream at a fixed bit rate derived from the system clock and pairs consecutive bits into an in-phase (I) bit and a quadrature (Q) bit. It holds the dibit stable for a full symbol period and flags each new symbol with a one-cycle load pulse. It sits between the bit source and the I/Q carrier mappers. On the receive side, the I/Q data selector performs the inverse merge and uses the same `sel` phase convention.

## Interface
Parameters:
- `BIT_DIV`, 8: clock cycles per input bit; legal range ≥ 2.
- `I_FIRST`, 1: 1 = first bit of each pair goes to I; 0 = first bit goes to Q.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; low = synchronous clear and idle.
- `din`  in  1  serial data; sampled only in the cycle `bit_tick` = 1.
- `bit_tick`  out  1  one-cycle pulse; `din` is sampled in this cycle and the upstream source advances to its next bit.
- `sel`  out  1  pair phase: 0 = next sampled bit is the first of a pair; 1 = next sampled bit is the second.
- `data_i`  out  1  held I bit.
- `data_q`  out  1  held Q bit.
- `sym_load`  out  1  one-cycle pulse; `data_i`/`data_q` changed on this edge.

## Operation
- **Divider:** `cnt` runs 0..BIT_DIV-1 while `en` = 1 and wraps at BIT_DIV-1. Width is $clog2(BIT_DIV).
- **Tick:** `bit_tick` = (`cnt` == BIT_DIV-1) && `en`. It is combinational from registered state and has no `din` dependence.
- **Phase FSM:** two states, FIRST (`sel` = 0) and SECOND (`sel` = 1).
  - FIRST + tick: capture `din` into `first_bit`, go to SECOND.
  - SECOND + tick: register the dibit, assert `sym_load` for the next cycle, go to FIRST.
- **Dibit mapping:**
  - I_FIRST = 1: `data_i` = `first_bit`, `data_q` = `din`.
  - I_FIRST = 0: the two are swapped.
- **Output hold:** `data_i`/`data_q` change only on a SECOND-state tick edge, and then hold for 2·BIT_DIV cycles.
- **Enable low:** on the next edge, clear `cnt`, the FSM (to FIRST), `first_bit`, `data_i`, `data_q` and `sym_load` to 0. Outputs stay 0 while `en` = 0.
  - A partially collected pair is discarded; it is never emitted.
- **Enable rising:** `cnt` starts from 0. The first `bit_tick` occurs BIT_DIV cycles later, and the first pair's phase is FIRST.
- **Reset:** asynchronous on `rst_n` = 0, same cleared state as enable-low. Reset mid-pair discards the pair. Release is synchronous to `clk` at the system level.

## Timing
- **Reset values:** `bit_tick` = 0, `sel` = 0, `data_i` = 0, `data_q` = 0, `sym_load` = 0.
- **Tick position:** with `en` high from edge E0, ticks fall in the cycles ending at edges E0+BIT_DIV, E0+2·BIT_DIV, and so on.
- **Symbol latency:** `data_i`/`data_q`/`sym_load` update on the edge that samples the second bit. `sym_load` is high for exactly the one cycle following that edge.
- **Symbol period:** exactly 2·BIT_DIV cycles between `sym_load` pulses in steady state. `sym_load` is never asserted for two consecutive cycles.
- **`sel` timing:** `sel` toggles on every tick edge.
- **Simultaneous events:**
  - `en` falling in a tick cycle: the tick is suppressed (tick is gated by `en`), so no sample and no load.
  - `rst_n` asserted in any cycle: overrides everything.

## Structure
- **Shared QPSK package:** `QPSK_BIT_DIV_DEFAULT` = 8, the phase encodings (`PH_FIRST` = 0, `PH_SECOND` = 1) and the I_FIRST convention constant. The receive-side selector uses the same definitions.
- **Sub-module `bit_rate_divider`:** parameter DIV; ports `clk`, `rst_n`, `en`, output `tick`. It owns `cnt`, and the splitter instantiates it once.
- **Splitter itself:** the two-state FSM, `first_bit`, and the output registers.

## Test plan
- **Reset:** hold `rst_n` = 0 with `en` = 1 and `din` toggling → all outputs 0. After release with `en` = 1, the first `bit_tick` occurs at cycle BIT_DIV.
- **Basic pairing:** BIT_DIV = 4, I_FIRST = 1, `din` sequence 1,0,1,1 presented on ticks.
  - Cycle 9: `data_i` = 1, `data_q` = 0, `sym_load` = 1.
  - Cycle 17: `data_i` = 1, `data_q` = 1.
  - `sym_load` is low at every other cycle; `sel` toggles each tick.
- **Swapped mapping:** I_FIRST = 0 with the same stream 1,0,1,1 → dibits (I,Q) = (0,1) then (1,1).
- **Enable drop mid-pair:** drop `en` one cycle after the first tick of a pair (`din` = 1) → outputs 0 next edge, no `sym_load`. Re-enable, send 0,1 → dibit (0,1); the stale 1 never appears.
- **Reset mid-symbol:** assert `rst_n` between the two ticks of a pair → outputs 0 immediately (asynchronously). After release, the pairing restarts with `sel` = 0.
- **Minimum divider:** BIT_DIV = 2, continuous random 64-bit stream → `sym_load` every 4 cycles, and every dibit matches the reference pairing model.
